// File: rtl/bp_cce_dir_sharers_read_if.sv
// Bus bundle for the directory sharers read-out engine: request handshake,
// directory RAM read port and the consolidated per-LCE sharers vectors.
interface bp_cce_dir_sharers_read_if #(
    parameter int num_lce_p        = 4,
    parameter int lce_assoc_p      = 8,
    parameter int tag_width_p      = 12,
    parameter int lces_per_row_p   = 2,
    parameter int row_addr_width_p = 8
) ();
    localparam int entry_width_lp = tag_width_p + 3;
    localparam int row_width_lp   = lces_per_row_p * lce_assoc_p * entry_width_lp;
    localparam int way_width_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;

    logic                              start_v_i;
    logic                              ready_o;
    logic [tag_width_p-1:0]            tag_i;
    logic [row_addr_width_p-1:0]       row_base_i;
    logic                              ram_v_o;
    logic [row_addr_width_p-1:0]       ram_row_o;
    logic [row_width_lp-1:0]           ram_data_i;
    logic                              sharers_v_o;
    logic [num_lce_p-1:0]              sharers_hits_o;
    logic [num_lce_p*way_width_lp-1:0] sharers_ways_o;
    logic [num_lce_p*3-1:0]            sharers_coh_states_o;
    logic                              multi_hit_o;

    // Engine side
    modport slave (
        input  start_v_i, tag_i, row_base_i, ram_data_i,
        output ready_o, ram_v_o, ram_row_o, sharers_v_o,
               sharers_hits_o, sharers_ways_o, sharers_coh_states_o, multi_hit_o
    );

    // Requester / RAM side
    modport master (
        output start_v_i, tag_i, row_base_i, ram_data_i,
        input  ready_o, ram_v_o, ram_row_o, sharers_v_o,
               sharers_hits_o, sharers_ways_o, sharers_coh_states_o, multi_hit_o
    );
endinterface

// File: rtl/bp_cce_dir_sharers_read.sv
// Directory sharers read-out engine: walks the RAM rows of one way-group,
// compares every stored entry against the target tag and builds per-LCE
// hit / way / coherence-state vectors, then pulses sharers_v_o once.
module bp_cce_dir_sharers_read #(
    parameter int num_lce_p        = 4,
    parameter int lce_assoc_p      = 8,
    parameter int tag_width_p      = 12,
    parameter int lces_per_row_p   = 2,
    parameter int row_addr_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bp_cce_dir_sharers_read_if.slave   bus
);
    localparam int num_rows_lp    = num_lce_p / lces_per_row_p;
    localparam int entry_width_lp = tag_width_p + 3;
    localparam int way_width_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
    localparam int cnt_width_lp   = (num_rows_lp > 1) ? $clog2(num_rows_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_row_lp = cnt_width_lp'(num_rows_lp - 1);

    localparam logic [1:0] e_ready = 2'd0;
    localparam logic [1:0] e_read  = 2'd1;
    localparam logic [1:0] e_drain = 2'd2;
    localparam logic [1:0] e_done  = 2'd3;

    // True when two or more ways of one LCE set match the target
    function automatic logic multi_match(input logic [lce_assoc_p-1:0] m);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int w = 0; w < lce_assoc_p; w++) begin
            multi = multi | (seen & m[w]);
            seen  = seen | m[w];
        end
        return multi;
    endfunction

    logic [1:0]                        state_r;
    logic [tag_width_p-1:0]            tag_r;
    logic [row_addr_width_p-1:0]       base_r;
    logic [cnt_width_lp-1:0]           cnt_r;
    logic [cnt_width_lp-1:0]           next_cnt_s;
    logic                              ready_r;
    logic                              ram_v_r;
    logic [row_addr_width_p-1:0]       ram_row_r;
    logic                              sharers_v_r;
    logic                              data_v_r;
    logic [cnt_width_lp-1:0]           data_row_r;
    logic [num_lce_p-1:0]              hits_r;
    logic [num_lce_p*way_width_lp-1:0] ways_r;
    logic [num_lce_p*3-1:0]            states_r;
    logic                              multi_r;
    logic                              accept_s;

    logic [lces_per_row_p-1:0][lce_assoc_p-1:0][entry_width_lp-1:0] row_entries_s;
    logic [lces_per_row_p-1:0][lce_assoc_p-1:0]                     match_s;
    logic [lces_per_row_p-1:0]                                      row_hit_s;
    logic [lces_per_row_p-1:0][way_width_lp-1:0]                    row_way_s;
    logic [lces_per_row_p-1:0][2:0]                                 row_state_s;
    logic                                                           row_multi_s;

    assign row_entries_s = bus.ram_data_i;
    assign next_cnt_s    = cnt_r + cnt_width_lp'(1);
    assign accept_s      = (state_r == e_ready) && bus.start_v_i;

    // Decode the returned row: per-LCE hit, lowest matching way and its state
    always_comb begin
        match_s     = '0;
        row_hit_s   = '0;
        row_way_s   = '0;
        row_state_s = '0;
        row_multi_s = 1'b0;
        for (int l = 0; l < lces_per_row_p; l++) begin
            for (int w = 0; w < lce_assoc_p; w++) begin
                match_s[l][w] = (row_entries_s[l][w][tag_width_p-1:0] == tag_r)
                             && (row_entries_s[l][w][entry_width_lp-1 -: 3] != 3'd0);
            end
        end
        for (int l = 0; l < lces_per_row_p; l++) begin
            row_hit_s[l] = |match_s[l];
            row_multi_s  = row_multi_s | multi_match(match_s[l]);
            // Scan high to low so the lowest matching way wins
            for (int w = lce_assoc_p - 1; w >= 0; w--) begin
                row_way_s[l]   = match_s[l][w] ? way_width_lp'(w) : row_way_s[l];
                row_state_s[l] = match_s[l][w] ? row_entries_s[l][w][entry_width_lp-1 -: 3]
                                               : row_state_s[l];
            end
        end
    end

    // Control FSM: accept request, issue row reads, drain last read, strobe done
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_ready;
            tag_r       <= '0;
            base_r      <= '0;
            cnt_r       <= '0;
            ready_r     <= 1'b1;
            ram_v_r     <= 1'b0;
            ram_row_r   <= '0;
            sharers_v_r <= 1'b0;
            data_v_r    <= 1'b0;
            data_row_r  <= '0;
        end else begin
            data_v_r   <= ram_v_r;
            data_row_r <= cnt_r;
            case (state_r)
                e_ready: begin
                    if (accept_s) begin
                        tag_r     <= bus.tag_i;
                        base_r    <= bus.row_base_i;
                        cnt_r     <= '0;
                        ready_r   <= 1'b0;
                        ram_v_r   <= 1'b1;
                        ram_row_r <= bus.row_base_i;
                        state_r   <= e_read;
                    end
                end
                e_read: begin
                    cnt_r <= next_cnt_s;
                    if (cnt_r == last_row_lp) begin
                        ram_v_r   <= 1'b0;
                        ram_row_r <= '0;
                        state_r   <= e_drain;
                    end else begin
                        ram_row_r <= base_r + row_addr_width_p'(next_cnt_s);
                    end
                end
                e_drain: begin
                    sharers_v_r <= 1'b1;
                    state_r     <= e_done;
                end
                e_done: begin
                    sharers_v_r <= 1'b0;
                    ready_r     <= 1'b1;
                    state_r     <= e_ready;
                end
                default: begin
                    ready_r     <= 1'b1;
                    ram_v_r     <= 1'b0;
                    ram_row_r   <= '0;
                    sharers_v_r <= 1'b0;
                    state_r     <= e_ready;
                end
            endcase
        end
    end

    // Sharers vectors: cleared on accept, filled as each row's data returns
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hits_r   <= '0;
            ways_r   <= '0;
            states_r <= '0;
            multi_r  <= 1'b0;
        end else if (accept_s) begin
            hits_r   <= '0;
            ways_r   <= '0;
            states_r <= '0;
            multi_r  <= 1'b0;
        end else if (data_v_r) begin
            for (int i = 0; i < num_lce_p; i++) begin
                if ((i / lces_per_row_p) == int'(data_row_r)) begin
                    hits_r[i]                               <= row_hit_s[i % lces_per_row_p];
                    ways_r[i*way_width_lp +: way_width_lp]  <= row_way_s[i % lces_per_row_p];
                    states_r[i*3 +: 3]                      <= row_state_s[i % lces_per_row_p];
                end
            end
            multi_r <= multi_r | row_multi_s;
        end
    end

    assign bus.ready_o              = ready_r;
    assign bus.ram_v_o              = ram_v_r;
    assign bus.ram_row_o            = ram_row_r;
    assign bus.sharers_v_o          = sharers_v_r;
    assign bus.sharers_hits_o       = hits_r;
    assign bus.sharers_ways_o       = ways_r;
    assign bus.sharers_coh_states_o = states_r;
    assign bus.multi_hit_o          = multi_r;
endmodule
